// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU pipeline control blocks.
package cpu_pkg;

  localparam int AW_DEF     = 5;
  localparam int ST_EX      = 0;
  localparam int ST_MEM     = 1;
  localparam int ST_WB      = 2;
  localparam int FWD_SEL_RF = 0;

  // Control flags of one shadow-pipeline entry; the destination address travels beside it.
  typedef struct packed {
    logic vld;
    logic wr;
    logic ld;
  } shadow_ctl_t;

endpackage

// File: rtl/fwd_src_match.sv
// Compares one source operand against every tracked stage and picks the youngest producer.
module fwd_src_match
  import cpu_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic [AW-1:0]       src,
  input  logic                used,
  input  logic [DEPTH-1:0]    vld,
  input  logic [DEPTH-1:0]    wr,
  input  logic [DEPTH*AW-1:0] rd,
  output logic [DEPTH-1:0]    match,
  output logic [SEL_W-1:0]    sel
);

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      match[s] = used && vld[s] && wr[s] &&
                 (rd[s*AW +: AW] != '0) && (rd[s*AW +: AW] == src);
    end
  end

  // Walk oldest to youngest so the lowest matching stage index is the one left standing.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (match[s]) sel = SEL_W'(s);
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit: shadows in-flight destinations EX..WB and drives bypass selects and load-use stall.
module fwd_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                id_valid_i,
  input  logic [NUM_SRC*AW-1:0]               id_src_i,
  input  logic [NUM_SRC-1:0]                  id_src_used_i,
  input  logic [AW-1:0]                       id_rd_i,
  input  logic                                id_regwrite_i,
  input  logic                                id_memread_i,
  input  logic                                flush_i,
  output logic                                stall_o,
  output logic [NUM_SRC*$clog2(DEPTH)-1:0]    ex_fwd_sel_o,
  output logic [NUM_SRC-1:0]                  id_wb_byp_o,
  output logic [15:0]                         stall_cnt_o
);

  localparam int SEL_W = $clog2(DEPTH);

  logic [DEPTH-1:0]                   sh_vld;
  logic [DEPTH-1:0]                   sh_wr;
  logic [DEPTH-1:0]                   sh_ld;
  logic [DEPTH*AW-1:0]                sh_rd;
  logic [NUM_SRC*AW-1:0]              ex_src_p0;
  logic [NUM_SRC-1:0]                 ex_used_p0;
  shadow_ctl_t                        id_ent;
  logic                               load_en;
  logic                               hazard;
  logic [NUM_SRC-1:0][DEPTH-1:0]      id_match;
  logic [NUM_SRC-1:0][DEPTH-1:0]      ex_match;
  logic [NUM_SRC-1:0][SEL_W-1:0]      id_sel;
  logic [NUM_SRC-1:0][SEL_W-1:0]      ex_sel;
  logic                               unused_bits;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_src_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_id_match (
      .src   (id_src_i[j*AW +: AW]),
      .used  (id_src_used_i[j]),
      .vld   (sh_vld),
      .wr    (sh_wr),
      .rd    (sh_rd),
      .match (id_match[j]),
      .sel   (id_sel[j])
    );

    // A bubble in EX carries stale sources; gating with its valid keeps them from selecting.
    fwd_src_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_ex_match (
      .src   (ex_src_p0[j*AW +: AW]),
      .used  (ex_used_p0[j] & sh_vld[ST_EX]),
      .vld   (sh_vld),
      .wr    (sh_wr),
      .rd    (sh_rd),
      .match (ex_match[j]),
      .sel   (ex_sel[j])
    );

    assign ex_fwd_sel_o[j*SEL_W +: SEL_W] = ex_sel[j];
    assign id_wb_byp_o[j]                 = id_valid_i && id_match[j][DEPTH-1];
  end

  // A load producer is not forwardable until it reaches LOAD_READY; anything younger forces a stall.
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int s = 0; s < LOAD_READY - 1; s++) begin
        if (id_match[j][s] && sh_ld[s]) hazard = 1'b1;
      end
    end
  end

  assign stall_o     = id_valid_i && !flush_i && hazard;
  assign load_en     = id_valid_i && !stall_o && !flush_i;
  assign id_ent      = '{vld: load_en, wr: id_regwrite_i, ld: id_memread_i};
  assign unused_bits = ^{id_sel, ex_match};

  // ID -> EX boundary and EX..WB shadow shift
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_vld <= '0;
    end else begin
      sh_vld <= {sh_vld[DEPTH-2:0], id_ent.vld};
    end
  end

  always_ff @(posedge clk_i) begin
    sh_wr      <= {sh_wr[DEPTH-2:0], id_ent.wr};
    sh_ld      <= {sh_ld[DEPTH-2:0], id_ent.ld};
    sh_rd      <= {sh_rd[(DEPTH-1)*AW-1:0], id_rd_i};
    ex_src_p0  <= id_src_i;
    ex_used_p0 <= id_src_used_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed hazard cases, random traffic against a stage-array model, counter saturation.
module tb_fwd_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int D   = 3;
  localparam int LR  = 2;
  localparam int SW  = 2;
  localparam int D2  = 32;
  localparam int LR2 = 31;
  localparam int SW2 = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [2*AW-1:0] id_src;
  logic [1:0]    id_used;
  logic [AW-1:0] id_rd;
  logic          id_wr;
  logic          id_ld;
  logic          flush;
  logic          stall;
  logic [2*SW-1:0] sel;
  logic [1:0]    byp;
  logic [15:0]   cnt;

  logic          rst2;
  logic          stall2;
  logic [2*SW2-1:0] sel2;
  logic [1:0]    byp2;
  logic [15:0]   cnt2;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_src_i      (id_src),
    .id_src_used_i (id_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_wr),
    .id_memread_i  (id_ld),
    .flush_i       (flush),
    .stall_o       (stall),
    .ex_fwd_sel_o  (sel),
    .id_wb_byp_o   (byp),
    .stall_cnt_o   (cnt)
  );

  fwd_hazard_scoreboard #(.DEPTH(D2), .LOAD_READY(LR2)) u_sat (
    .clk_i         (clk),
    .rst_i         (rst2),
    .id_valid_i    (1'b1),
    .id_src_i      ({5'd0, 5'd5}),
    .id_src_used_i (2'b01),
    .id_rd_i       (5'd5),
    .id_regwrite_i (1'b1),
    .id_memread_i  (1'b1),
    .flush_i       (1'b0),
    .stall_o       (stall2),
    .ex_fwd_sel_o  (sel2),
    .id_wb_byp_o   (byp2),
    .stall_cnt_o   (cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per tracked stage, index 0 = EX.
  bit p_vld [D];
  bit p_wr  [D];
  bit p_ld  [D];
  int p_rd  [D];
  int p_src [D][2];
  bit p_used[D][2];
  int m_cnt = 0;

  bit       exp_stall;
  int       exp_sel[2];
  bit [1:0] exp_byp;

  function automatic bit hit(int s, int src, bit used);
    return p_vld[s] && p_wr[s] && (p_rd[s] != 0) && (p_rd[s] == src) && used;
  endfunction

  task automatic settle();
    int sj[2];
    bit uj[2];
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      sj[j] = int'(id_src[j*AW +: AW]);
      uj[j] = id_used[j];
    end
    exp_stall = 1'b0;
    if (id_valid && !flush)
      for (int j = 0; j < 2; j++)
        for (int s = 0; s < D; s++)
          if (s + 1 < LR && p_ld[s] && hit(s, sj[j], uj[j])) exp_stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      exp_sel[j] = 0;
      if (p_vld[0])
        for (int s = D - 1; s >= 1; s--)
          if (hit(s, p_src[0][j], p_used[0][j])) exp_sel[j] = s;
      exp_byp[j] = id_valid && hit(D - 1, sj[j], uj[j]);
    end
    check("stall", 32'(stall), 32'(exp_stall));
    check("sel0", 32'(sel[SW-1:0]), exp_sel[0]);
    check("sel1", 32'(sel[2*SW-1:SW]), exp_sel[1]);
    check("byp", 32'(byp), 32'(exp_byp));
    check("cnt", 32'(cnt), m_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < D; s++) p_vld[s] = 1'b0;
      m_cnt = 0;
    end else begin
      if (exp_stall && m_cnt < 65535) m_cnt++;
      for (int s = D - 1; s >= 1; s--) begin
        p_vld[s] = p_vld[s-1]; p_wr[s] = p_wr[s-1]; p_ld[s] = p_ld[s-1]; p_rd[s] = p_rd[s-1];
        for (int j = 0; j < 2; j++) begin
          p_src[s][j] = p_src[s-1][j]; p_used[s][j] = p_used[s-1][j];
        end
      end
      p_vld[0] = id_valid && !exp_stall && !flush;
      p_wr[0]  = id_wr;
      p_ld[0]  = id_ld;
      p_rd[0]  = int'(id_rd);
      for (int j = 0; j < 2; j++) begin
        p_src[0][j]  = int'(id_src[j*AW +: AW]);
        p_used[0][j] = id_used[j];
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] u,
                       input int rd, input bit wr, input bit ld, input bit fl);
    id_valid = v;
    id_src   = {AW'(s1), AW'(s0)};
    id_used  = u;
    id_rd    = AW'(rd);
    id_wr    = wr;
    id_ld    = ld;
    flush    = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  bit occ[D2];
  int stalls = 0;

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    nop();
    advance();
    advance();
    rst = 1'b0;

    // reset state
    settle();
    check("rst_stall", 32'(stall), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_sel", 32'(sel), 0);
    advance();

    // 1: ALU producer in EX, consumer forwarded from MEM
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0); cyc();
    drive(1, 3, 0, 2'b01, 8, 1, 0, 0); settle();
    check("t1_stall", 32'(stall), 0);
    advance();
    nop(); settle();
    check("t1_sel0", 32'(sel[SW-1:0]), 1);
    advance();

    // 2: load-use stall for one cycle, then forward from WB
    drive(1, 1, 2, 2'b00, 5, 1, 1, 0); cyc();
    drive(1, 5, 0, 2'b01, 9, 1, 0, 0); settle();
    check("t2_stall_on", 32'(stall), 1);
    advance();
    settle();
    check("t2_stall_off", 32'(stall), 0);
    check("t2_cnt", 32'(cnt), 1);
    advance();
    nop(); settle();
    check("t2_sel0", 32'(sel[SW-1:0]), 2);
    advance();

    // 3: r4 in MEM and WB, youngest wins
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0); cyc();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0); cyc();
    drive(1, 11, 4, 2'b11, 10, 1, 0, 0); cyc();
    nop(); settle();
    check("t3_sel1", 32'(sel[2*SW-1:SW]), 1);
    check("t3_sel0", 32'(sel[SW-1:0]), 0);
    advance();

    // 4: WB write-through, then r0 producer ignored
    drive(1, 0, 0, 2'b00, 7, 1, 0, 0); cyc();
    nop(); cyc();
    nop(); cyc();
    drive(1, 7, 0, 2'b01, 12, 1, 0, 0); settle();
    check("t4_byp", 32'(byp), 1);
    advance();
    drive(1, 0, 0, 2'b00, 0, 1, 1, 0); cyc();
    drive(1, 0, 0, 2'b11, 13, 1, 0, 0); settle();
    check("t4_r0_stall", 32'(stall), 0);
    check("t4_r0_byp", 32'(byp), 0);
    advance();
    nop(); settle();
    check("t4_r0_sel", 32'(sel), 0);
    advance();

    // 5: flush beats load-use stall
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0); cyc();
    drive(1, 5, 5, 2'b11, 14, 1, 0, 1); settle();
    check("t5_stall", 32'(stall), 0);
    advance();
    nop(); settle();
    check("t5_sel_a", 32'(sel), 0);
    check("t5_cnt", 32'(cnt), 1);
    advance();
    settle();
    check("t5_sel_b", 32'(sel), 0);
    advance();

    // 6: reset in the middle of a stall
    drive(1, 0, 0, 2'b00, 6, 1, 1, 0); cyc();
    drive(1, 6, 0, 2'b01, 15, 1, 0, 0); settle();
    check("t6_stall_pre", 32'(stall), 1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    settle();
    check("t6_stall", 32'(stall), 0);
    check("t6_sel", 32'(sel), 0);
    check("t6_byp", 32'(byp), 0);
    check("t6_cnt", 32'(cnt), 0);
    advance();

    // random traffic; ID is normally held while stalled
    for (int i = 0; i < 2000; i++) begin
      if (!exp_stall || $urandom_range(3) == 0)
        drive($urandom_range(9) < 8, $urandom_range(7), $urandom_range(7), 2'($urandom_range(3)),
              $urandom_range(7), $urandom_range(3) != 0, $urandom_range(2) == 0,
              $urandom_range(9) == 0);
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 1'b0;
    nop();

    // saturation: deep instance with a chain of dependent loads
    @(negedge clk);
    check("sat_rst_cnt", 32'(cnt2), 0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int c = 0; c < 80000 && stalls < 70000; c++) begin
      bit es;
      int esel;
      @(negedge clk);
      es = 1'b0;
      for (int s = 0; s < LR2 - 1; s++) if (occ[s]) es = 1'b1;
      esel = 0;
      if (occ[0])
        for (int s = D2 - 1; s >= 1; s--) if (occ[s]) esel = s;
      check("sat_stall", 32'(stall2), 32'(es));
      check("sat_sel0", 32'(sel2[SW2-1:0]), esel);
      check("sat_sel1", 32'(sel2[2*SW2-1:SW2]), 0);
      check("sat_byp", 32'(byp2), 32'(occ[D2-1]));
      @(posedge clk);
      if (es) stalls++;
      for (int s = D2 - 1; s >= 1; s--) occ[s] = occ[s-1];
      occ[0] = !es;
      #1;
      if (es && stalls == 1000)  check("sat_cnt_1000", 32'(cnt2), 1000);
      if (es && stalls == 65535) check("sat_cnt_max", 32'(cnt2), 32'hFFFF);
    end
    if (stalls < 70000) check("sat_budget", stalls, 70000);
    @(negedge clk);
    check("sat_cnt_final", 32'(cnt2), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
